// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the UART command sequencer.
package uart_seq_pkg;

    // Playback FSM encoding.
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t StIdle   = 3'd0;
    localparam seq_state_t StDelay  = 3'd1;
    localparam seq_state_t StSend   = 3'd2;
    localparam seq_state_t StWaitTx = 3'd3;
    localparam seq_state_t StFin    = 3'd4;

    // Default wait for tx_done before the current byte is abandoned.
    localparam int unsigned DEF_TO_CYC = 65536;

    // One script entry at the default widths (8-bit command, 24-bit delay).
    typedef struct packed {
        logic [7:0]  cmd;
        logic [23:0] dly;
    } script_entry_t;

endpackage

// File: rtl/uart_cmd_sequencer_ram.sv
// Script table: one synchronous write port, one asynchronous read port. Contents are not reset.
module seq_script_ram #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store a script entry.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Replays a loadable table of command bytes into UART_tx, each after a programmable idle delay.
module uart_cmd_sequencer import uart_seq_pkg::*; #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CMD_W  = 8,
    parameter int unsigned DLY_W  = 24,
    parameter int unsigned TO_CYC = DEF_TO_CYC
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [CMD_W-1:0]         wr_cmd_i,
    input  logic [DLY_W-1:0]         wr_dly_i,
    input  logic [$clog2(DEPTH):0]   len_i,
    input  logic                     loop_en_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     tx_done_i,
    output logic                     trmt_o,
    output logic [CMD_W-1:0]         tx_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic                     wr_err_o,
    output logic [$clog2(DEPTH)-1:0] cur_idx_o,
    output logic [15:0]              sent_cnt_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned ToW  = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [ToW-1:0]  ToLast = ToW'(TO_CYC - 1);
    localparam logic [IdxW:0]   LenOne = {{IdxW{1'b0}}, 1'b1};
    localparam logic [IdxW-1:0] IdxOne = {{(IdxW-1){1'b0}}, 1'b1};

    seq_state_t       state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [ToW-1:0]   to_cnt_q, to_cnt_d;
    logic             trmt_q, trmt_d;
    logic [CMD_W-1:0] tx_data_q, tx_data_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             wr_err_q, wr_err_d;
    logic [15:0]      sent_cnt_q, sent_cnt_d;
    logic [IdxW:0]    len_q, len_d;
    logic             loop_q, loop_d;
    logic             tx_done_q;

    logic                   tx_rise;
    logic                   last_entry;
    logic                   ram_we;
    logic [IdxW-1:0]        rd_addr;
    logic [CMD_W+DLY_W-1:0] rd_data;
    logic [CMD_W-1:0]       rd_cmd;
    logic [DLY_W-1:0]       rd_dly;
    logic [DLY_W-1:0]       first_dly;

    assign tx_rise    = tx_done_i & ~tx_done_q;
    assign last_entry = ({1'b0, idx_q} == (len_q - LenOne));
    assign ram_we     = wr_en_i && (state_q == StIdle);
    assign rd_cmd     = rd_data[CMD_W+DLY_W-1 -: CMD_W];
    assign rd_dly     = rd_data[DLY_W-1:0];
    // A write to entry 0 in the start cycle lands at the same edge, so forward its delay.
    assign first_dly  = (wr_en_i && (wr_addr_i == '0)) ? wr_dly_i : rd_dly;

    seq_script_ram #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W + DLY_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (wr_addr_i),
        .wdata_i ({wr_cmd_i, wr_dly_i}),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Read address points at the entry the FSM loads from next.
    always_comb begin
        rd_addr = idx_q;
        if (state_q == StIdle || (state_q == StWaitTx && last_entry)) begin
            rd_addr = '0;
        end else if (state_q == StWaitTx) begin
            rd_addr = idx_q + IdxOne;
        end
    end

    // Playback FSM and counter next-state.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dly_cnt_d  = dly_cnt_q;
        to_cnt_d   = to_cnt_q;
        trmt_d     = 1'b0;
        tx_data_d  = tx_data_q;
        done_d     = 1'b0;
        timeout_d  = timeout_q;
        sent_cnt_d = sent_cnt_q;
        len_d      = len_q;
        loop_d     = loop_q;
        wr_err_d   = wr_en_i && (state_q != StIdle);
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        timeout_d  = 1'b0;
                        sent_cnt_d = '0;
                        if (len_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d   = StDelay;
                            idx_d     = '0;
                            dly_cnt_d = first_dly;
                            len_d     = len_i;
                            loop_d    = loop_en_i;
                        end
                    end
                end
                StDelay: begin
                    if (dly_cnt_q == '0) begin
                        // trmt is registered so it is high for the whole SEND cycle.
                        state_d   = StSend;
                        trmt_d    = 1'b1;
                        tx_data_d = rd_cmd;
                    end else begin
                        dly_cnt_d = dly_cnt_q - 1'b1;
                    end
                end
                StSend: begin
                    state_d  = StWaitTx;
                    to_cnt_d = '0;
                end
                StWaitTx: begin
                    if (tx_rise) begin
                        if (sent_cnt_q != 16'hFFFF) begin
                            sent_cnt_d = sent_cnt_q + 16'd1;
                        end
                        if (last_entry && !loop_q) begin
                            state_d = StFin;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = StDelay;
                            idx_d     = last_entry ? '0 : idx_q + IdxOne;
                            dly_cnt_d = rd_dly;
                        end
                    end else if (to_cnt_q == ToLast) begin
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                StFin: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with synchronous reset; the tx_done edge register samples every cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            dly_cnt_q  <= '0;
            to_cnt_q   <= '0;
            trmt_q     <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            sent_cnt_q <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dly_cnt_q  <= dly_cnt_d;
            to_cnt_q   <= to_cnt_d;
            trmt_q     <= trmt_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            wr_err_q   <= wr_err_d;
            sent_cnt_q <= sent_cnt_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            tx_done_q  <= tx_done_i;
        end
    end

    assign trmt_o     = trmt_q;
    assign tx_data_o  = tx_data_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign timeout_o  = timeout_q;
    assign wr_err_o   = wr_err_q;
    assign cur_idx_o  = idx_q;
    assign sent_cnt_o = sent_cnt_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench: sequencer driving a behavioural UART_tx stand-in that logs every trmt.
module tb_uart_cmd_sequencer;

    localparam int unsigned TO   = 1000;
    localparam int          FRAME = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_cmd = '0;
    logic [23:0] wr_dly = '0;
    logic [3:0]  len = '0;
    logic        loop_en = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tx_done;
    logic        trmt, busy, done, timeout, wr_err;
    logic [7:0]  tx_data;
    logic [2:0]  cur_idx;
    logic [15:0] sent_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // UART_tx stand-in: tx_done rises FRAME cycles after trmt and stays high until the next trmt.
    int         cyc = 0;
    int         rx_n = 0;
    int         done_cnt = 0;
    int         stub_cnt = 0;
    int         stub_mode = 0;  // 0 normal, 1 tied low, 2 tied high
    logic       tx_done_r = 1'b0;
    logic [7:0] rx_byte [256];
    int         trmt_cyc [256];

    assign tx_done = (stub_mode == 0) ? tx_done_r : (stub_mode == 2);

    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        done_cnt <= done_cnt + (done ? 1 : 0);
        if (trmt) begin
            if (rx_n < 256) begin
                rx_byte[rx_n]  <= tx_data;
                trmt_cyc[rx_n] <= cyc;
            end
            rx_n      <= rx_n + 1;
            stub_cnt  <= FRAME;
            tx_done_r <= 1'b0;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) tx_done_r <= 1'b1;
        end
    end

    uart_cmd_sequencer #(
        .DEPTH  (8),
        .CMD_W  (8),
        .DLY_W  (24),
        .TO_CYC (TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_cmd_i   (wr_cmd),
        .wr_dly_i   (wr_dly),
        .len_i      (len),
        .loop_en_i  (loop_en),
        .start_i    (start),
        .abort_i    (abort),
        .tx_done_i  (tx_done),
        .trmt_o     (trmt),
        .tx_data_o  (tx_data),
        .busy_o     (busy),
        .done_o     (done),
        .timeout_o  (timeout),
        .wr_err_o   (wr_err),
        .cur_idx_o  (cur_idx),
        .sent_cnt_o (sent_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] c, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_cmd = c; wr_dly = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int budget, output bit ok);
        int n = 0;
        while (rx_n < target && n < budget) begin tick(); n++; end
        ok = (rx_n >= target);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        ok = !busy;
    endtask

    task automatic test_reset();
        tick(); tick(); tick();
        n_checks++;
        if ({trmt, busy, done, timeout, wr_err} !== 5'b0 || tx_data !== 8'h00
            || cur_idx !== 3'd0 || sent_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_state: got trmt/busy/done/to/werr=%b%b%b%b%b data=%h idx=%0d cnt=%0d required all zero",
                     trmt, busy, done, timeout, wr_err, tx_data, cur_idx, sent_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_two_cmds();
        int s, base, d0;
        bit ok;
        load(3'd0, "g", 24'd100);
        load(3'd1, "s", 24'd0);
        len = 4'd2; loop_en = 1'b0;
        base = rx_n; d0 = done_cnt;
        pulse_start(s);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL busy_after_start: got %b required 1", busy); end
        wait_rx(base + 2, 2000, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL two_cmds_rx: got %0d bytes required 2", rx_n - base); end
        n_checks++;
        if (trmt_cyc[base] - s !== 102) begin
            n_errors++; $display("FAIL first_trmt_latency: got %0d required 102", trmt_cyc[base] - s);
        end
        n_checks++;
        if (rx_byte[base] !== "g" || rx_byte[base+1] !== "s") begin
            n_errors++; $display("FAIL two_cmds_bytes: got %h %h required 67 73", rx_byte[base], rx_byte[base+1]);
        end
        wait_idle(500, ok);
        n_checks++;
        if (!ok || done_cnt - d0 !== 1) begin
            n_errors++; $display("FAIL two_cmds_done: got %0d done pulses required 1", done_cnt - d0);
        end
        n_checks++;
        if (sent_cnt !== 16'd2 || tx_data !== "s") begin
            n_errors++; $display("FAIL two_cmds_cnt: got cnt=%0d data=%h required cnt=2 data=73", sent_cnt, tx_data);
        end
    endtask

    task automatic test_loop_abort();
        int s, base, d0, n_rx;
        bit ok;
        logic [7:0] exp_seq [7];
        exp_seq = '{"a", "b", "c", "a", "b", "c", "a"};
        load(3'd0, "a", 24'd5);
        load(3'd1, "b", 24'd5);
        load(3'd2, "c", 24'd5);
        len = 4'd3; loop_en = 1'b1;
        base = rx_n; d0 = done_cnt;
        pulse_start(s);
        wait_rx(base + 7, 3000, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL loop_rx: got %0d bytes required 7", rx_n - base); end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (rx_byte[base+i] !== exp_seq[i]) begin
                n_errors++; $display("FAIL loop_byte%0d: got %h required %h", i, rx_byte[base+i], exp_seq[i]);
            end
        end
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b required 0", busy); end
        n_rx = rx_n;
        for (int i = 0; i < 200; i++) tick();
        n_checks++;
        if (rx_n !== n_rx || done_cnt !== d0) begin
            n_errors++; $display("FAIL abort_quiet: got %0d extra trmt %0d done required 0 0", rx_n - n_rx, done_cnt - d0);
        end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_with_start: got busy=%b required 0", busy); end
        loop_en = 1'b0;
    endtask

    task automatic test_timeout();
        int s, base, t;
        bit ok;
        stub_mode = 1;
        load(3'd0, "x", 24'd0);
        len = 4'd1;
        base = rx_n;
        pulse_start(s);
        wait_rx(base + 1, 100, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL timeout_trmt: got %0d bytes required 1", rx_n - base); end
        t = trmt_cyc[base];
        while (cyc < t + int'(TO) - 1) tick();
        n_checks++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            n_errors++; $display("FAIL timeout_early: got to=%b busy=%b required 0 1", timeout, busy);
        end
        while (cyc < t + int'(TO) + 1) tick();
        n_checks++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            n_errors++; $display("FAIL timeout_set: got to=%b busy=%b required 1 0", timeout, busy);
        end
        stub_mode = 0;
        pulse_start(s);
        n_checks++;
        if (timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_clear: got %b required 0", timeout); end
        wait_idle(500, ok);
        n_checks++;
        if (!ok || sent_cnt !== 16'd1) begin
            n_errors++; $display("FAIL timeout_replay: got cnt=%0d required 1", sent_cnt);
        end
    endtask

    task automatic test_writes();
        int s, base, d0;
        bit ok;
        load(3'd0, "p", 24'd30);
        len = 4'd1;
        pulse_start(s);
        tick(); tick();
        wr_en = 1'b1; wr_addr = 3'd0; wr_cmd = "q"; wr_dly = 24'd0;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (wr_err !== 1'b1) begin n_errors++; $display("FAIL wr_err_pulse: got %b required 1", wr_err); end
        tick();
        n_checks++;
        if (wr_err !== 1'b0) begin n_errors++; $display("FAIL wr_err_width: got %b required 0", wr_err); end
        wait_idle(500, ok);
        base = rx_n;
        pulse_start(s);
        wait_rx(base + 1, 200, ok);
        n_checks++;
        if (!ok || rx_byte[base] !== "p" || trmt_cyc[base] - s !== 32) begin
            n_errors++; $display("FAIL dropped_write: got byte=%h lat=%0d required 70 32", rx_byte[base], trmt_cyc[base] - s);
        end
        wait_idle(500, ok);
        len = 4'd0;
        base = rx_n; d0 = done_cnt;
        pulse_start(s);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_errors++; $display("FAIL len0_done: got done=%b busy=%b required 1 0", done, busy);
        end
        tick(); tick();
        n_checks++;
        if (done_cnt - d0 !== 1 || rx_n !== base) begin
            n_errors++; $display("FAIL len0_quiet: got %0d done %0d trmt required 1 0", done_cnt - d0, rx_n - base);
        end
        len = 4'd1;
        base = rx_n;
        wr_en = 1'b1; wr_addr = 3'd0; wr_cmd = "w"; wr_dly = 24'd3;
        start = 1'b1; s = cyc;
        tick();
        wr_en = 1'b0; start = 1'b0;
        wait_rx(base + 1, 100, ok);
        n_checks++;
        if (!ok || rx_byte[base] !== "w" || trmt_cyc[base] - s !== 5) begin
            n_errors++; $display("FAIL write_start_same: got byte=%h lat=%0d required 77 5", rx_byte[base], trmt_cyc[base] - s);
        end
        wait_idle(500, ok);
    endtask

    task automatic test_held_done_and_rst();
        int s, d0, n_rx;
        bit ok;
        stub_mode = 2;
        load(3'd0, "h", 24'd0);
        len = 4'd1;
        d0 = done_cnt;
        pulse_start(s);
        for (int i = 0; i < 100; i++) tick();
        n_checks++;
        if (busy !== 1'b1 || sent_cnt !== 16'd0) begin
            n_errors++; $display("FAIL held_tx_done: got busy=%b cnt=%0d required 1 0", busy, sent_cnt);
        end
        stub_mode = 1;
        tick();
        stub_mode = 2;
        wait_idle(50, ok);
        n_checks++;
        if (!ok || sent_cnt !== 16'd1 || done_cnt - d0 !== 1) begin
            n_errors++; $display("FAIL fresh_edge: got cnt=%0d done=%0d required 1 1", sent_cnt, done_cnt - d0);
        end
        stub_mode = 0;
        load(3'd0, "r", 24'd200);
        pulse_start(s);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({trmt, busy, done, timeout, wr_err} !== 5'b0 || tx_data !== 8'h00
            || cur_idx !== 3'd0 || sent_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL rst_mid_delay: got busy=%b data=%h idx=%0d cnt=%0d required all zero",
                     busy, tx_data, cur_idx, sent_cnt);
        end
        n_rx = rx_n;
        for (int i = 0; i < 250; i++) tick();
        n_checks++;
        if (rx_n !== n_rx) begin n_errors++; $display("FAIL rst_quiet: got %0d trmt required 0", rx_n - n_rx); end
    endtask

    initial begin
        test_reset();
        test_two_cmds();
        test_loop_abort();
        test_timeout();
        test_writes();
        test_held_done_and_rst();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
